// File: rtl/toggle_counter_if.sv
// Control and status bundle for toggle_counter.
// The master drives the count controls and the slave returns the count and its flags.
interface toggle_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up, load, d,
        input  q, tc, wrap
    );

    modport slave (
        input  en, up, load, d,
        output q, tc, wrap
    );
endinterface

// File: rtl/toggle_counter.sv
// Modulo-MODULUS up/down counter with clamped parallel load and a registered boundary pulse.
// Define TOGGLE_COUNTER_SAT_EN to hold at the limits instead of wrapping; wrap still pulses at each limit hit.
module toggle_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    toggle_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

`ifdef TOGGLE_COUNTER_SAT_EN
    localparam logic [WIDTH-1:0] UP_EDGE_NEXT   = MAX_VAL;
    localparam logic [WIDTH-1:0] DOWN_EDGE_NEXT = '0;
`else
    localparam logic [WIDTH-1:0] UP_EDGE_NEXT   = '0;
    localparam logic [WIDTH-1:0] DOWN_EDGE_NEXT = MAX_VAL;
`endif

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;
    logic [WIDTH-1:0] w_d_clamped;
    logic             w_at_max;
    logic             w_at_min;

    assign w_at_max    = (r_q == MAX_VAL);
    assign w_at_min    = (r_q == '0);
    assign w_d_clamped = (bus.d > MAX_VAL) ? MAX_VAL : bus.d;

    // Load outranks counting; only a counting step at a limit raises wrap.
    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        if (bus.load) begin
            w_q_next = w_d_clamped;
        end else if (bus.en) begin
            if (bus.up) begin
                if (w_at_max) begin
                    w_q_next    = UP_EDGE_NEXT;
                    w_wrap_next = 1'b1;
                end else begin
                    w_q_next = r_q + WIDTH'(1);
                end
            end else begin
                if (w_at_min) begin
                    w_q_next    = DOWN_EDGE_NEXT;
                    w_wrap_next = 1'b1;
                end else begin
                    w_q_next = r_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign bus.q    = r_q;
    assign bus.wrap = r_wrap;
    assign bus.tc   = bus.en & ((bus.up & w_at_max) | (~bus.up & w_at_min));
endmodule

// File: tb/tb_toggle_counter.sv
// Scoreboard bench for toggle_counter: a MOD-10 instance (A) and a 1-bit MOD-2 instance (B).
// The driver queues hand-computed expectations; the monitor pops and compares q, wrap and tc.
module tb_toggle_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    toggle_counter_if #(.WIDTH(4)) bus_a ();
    toggle_counter_if #(.WIDTH(1)) bus_b ();

    toggle_counter #(.WIDTH(4), .MODULUS(10)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    toggle_counter #(.WIDTH(1), .MODULUS(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct packed {
        logic       sel;
        logic [3:0] q;
        logic       wrap;
        logic       tc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;
    logic  vld   = 1'b0;

`ifdef TOGGLE_COUNTER_SAT_EN
    int run_q[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
    int run_f[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
`else
    int run_q[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int run_f[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
`endif

    task automatic drive(input string nm, input logic sel, input logic r, input logic ld,
                         input logic e, input logic u, input logic [3:0] dv,
                         input logic [3:0] eq, input logic ew, input logic etc);
        exp_t x;
        @(negedge clk);
        #1;
        rst         = r;
        bus_a.load  = sel ? 1'b0 : ld;
        bus_a.en    = sel ? 1'b0 : e;
        bus_a.up    = u;
        bus_a.d     = dv;
        bus_b.load  = sel ? ld : 1'b0;
        bus_b.en    = sel ? e : 1'b0;
        bus_b.up    = u;
        bus_b.d     = dv[0];
        x.sel  = sel;
        x.q    = eq;
        x.wrap = ew;
        x.tc   = etc;
        exp_q.push_back(x);
        name_q.push_back(nm);
        vld = 1'b1;
    endtask

    // Monitor: tc just before the edge, q/wrap just after it.
    initial begin
        logic       had;
        logic       tc_s;
        logic [3:0] q_s;
        logic       w_s;
        exp_t       x;
        string      nm;
        forever begin
            @(negedge clk);
            #3;
            had  = vld;
            tc_s = 1'b0;
            if (had && exp_q.size() > 0)
                tc_s = exp_q[0].sel ? bus_b.tc : bus_a.tc;
            @(posedge clk);
            #1;
            if (had) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_underflow: got empty queue, want an entry");
                end else begin
                    x  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    q_s = x.sel ? {3'b000, bus_b.q} : bus_a.q;
                    w_s = x.sel ? bus_b.wrap : bus_a.wrap;
                    total += 3;
                    if (q_s !== x.q) begin
                        bad++;
                        $display("FAIL %s q: got %0d want %0d", nm, q_s, x.q);
                    end
                    if (w_s !== x.wrap) begin
                        bad++;
                        $display("FAIL %s wrap: got %0b want %0b", nm, w_s, x.wrap);
                    end
                    if (tc_s !== x.tc) begin
                        bad++;
                        $display("FAIL %s tc: got %0b want %0b", nm, tc_s, x.tc);
                    end
                    $display("txn %s: q=%0d wrap=%0b tc=%0b", nm, q_s, w_s, tc_s);
                end
            end
        end
    end

    initial begin
        logic       p;
        logic       u;
        logic [3:0] qb;
        bus_a.en = 1'b0; bus_a.up = 1'b0; bus_a.load = 1'b0; bus_a.d = '0;
        bus_b.en = 1'b0; bus_b.up = 1'b0; bus_b.load = 1'b0; bus_b.d = '0;

        drive("reset", 0, 1, 0, 0, 0, 4'd0, 4'd0, 0, 0);
        for (int i = 0; i < 12; i++)
            drive("count_up", 0, 0, 0, 1, 1, 4'd0, 4'(run_q[i]), run_f[i] != 0, run_f[i] != 0);

        drive("load7", 0, 0, 1, 0, 0, 4'd7, 4'd7, 0, 0);
        for (int i = 0; i < 5; i++)
            drive("hold7", 0, 0, 0, 0, 1, 4'd0, 4'd7, 0, 0);

        drive("load_clamp", 0, 0, 1, 0, 0, 4'd13, 4'd9, 0, 0);
        drive("load_beats_en", 0, 0, 1, 1, 1, 4'd3, 4'd3, 0, 1);

        drive("load0", 0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 0);
`ifdef TOGGLE_COUNTER_SAT_EN
        drive("down_edge", 0, 0, 0, 1, 0, 4'd0, 4'd0, 1, 1);
        drive("after_edge", 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0);
`else
        drive("down_edge", 0, 0, 0, 1, 0, 4'd0, 4'd9, 1, 1);
        drive("after_edge", 0, 0, 0, 0, 0, 4'd0, 4'd9, 0, 0);
`endif

        drive("load5", 0, 0, 1, 0, 0, 4'd5, 4'd5, 0, 0);
        drive("down1", 0, 0, 0, 1, 0, 4'd0, 4'd4, 0, 0);
        drive("down2", 0, 0, 0, 1, 0, 4'd0, 4'd3, 0, 0);
        drive("dir_change", 0, 0, 0, 1, 1, 4'd0, 4'd4, 0, 0);

        drive("load5b", 0, 0, 1, 0, 0, 4'd5, 4'd5, 0, 0);
        drive("rst_beats_load", 0, 1, 1, 1, 1, 4'd3, 4'd0, 0, 0);

        drive("load6", 0, 0, 1, 0, 0, 4'd6, 4'd6, 0, 0);
        drive("rst_glitch", 0, 0, 0, 0, 0, 4'd0, 4'd6, 0, 0);
        #1 rst = 1'b1;
        #1 rst = 1'b0;

        drive("load9", 0, 0, 1, 0, 0, 4'd9, 4'd9, 0, 0);
        drive("rst_at_max", 0, 1, 0, 1, 1, 4'd0, 4'd0, 0, 1);
        drive("post_rst", 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0);

`ifndef TOGGLE_COUNTER_SAT_EN
        p = 1'b0;
        for (int i = 0; i < 4; i++) begin
            u  = 1'($urandom_range(0, 1));
            qb = (i % 2 == 0) ? 4'd1 : 4'd0;
            drive("tff", 1, 0, 0, 1, u, 4'd0, qb, (u == p), (u == p));
            p = qb[0];
        end
`endif

        @(negedge clk);
        #1;
        vld = 1'b0;
        bus_a.en = 1'b0; bus_a.load = 1'b0;
        bus_b.en = 1'b0; bus_b.load = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/toggle_counter.md
TOGGLE_COUNTER -- requirements
Module: toggle_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter width in bits (legal range 1..16).
REQ-002 SHALL have parameter MODULUS, default 16, giving the count range 0..MODULUS-1 (legal range 2..2**WIDTH).
REQ-003 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-008 SHALL have port d  input  WIDTH  parallel load value.
REQ-009 SHALL have port q  output  WIDTH  registered count value.
REQ-010 SHALL have port tc  output  1  combinational terminal-count indicator.
REQ-011 SHALL have port wrap  output  1  registered one-cycle pulse marking a boundary event.

Function
REQ-012 SHALL evaluate inputs only at the rising edge of clk, with priority rst > load > en.
REQ-013 SHALL set q to d on load=1, regardless of en and up.
REQ-014 SHALL clamp a load value d >= MODULUS to MODULUS-1.
REQ-015 SHALL take q to q+1 on en=1, up=1, q<MODULUS-1.
REQ-016 SHALL take q to q-1 on en=1, up=0, q>0.
REQ-017 SHALL hold q when en=0 and load=0.
REQ-018 SHALL handle an up boundary (en=1, up=1, q=MODULUS-1) as follows: q goes to 0 and wrap=1 for the following cycle (wrap build).
REQ-019 SHALL handle a down boundary (en=1, up=0, q=0) as follows: q goes to MODULUS-1 and wrap=1 for the following cycle (wrap build).
REQ-020 SHALL drive wrap=0 in every cycle that does not follow a boundary event; a load cycle never sets wrap.
REQ-021 SHALL drive tc = en & ((up & q==MODULUS-1) | (~up & q==0)), with no clock latency.
REQ-022 SHALL keep q within 0..MODULUS-1 at all times after the first reset.
REQ-023 SHALL apply a direction change on the same edge it is sampled, with no extra latency.
REQ-024 SHALL, when MODULUS=2 and WIDTH=1, behave as a toggle flip-flop: en=1 inverts q on every edge for either value of up.

Reset
REQ-025 SHALL drive q=0 and wrap=0 on the edge after rst=1 is sampled.
REQ-026 SHALL let rst override load and en in the same cycle.
REQ-027 SHALL treat reset mid-count as follows: the next value is 0 and no wrap pulse is produced.
REQ-028 SHALL not respond asynchronously to rst; q holds until the next clk edge.

Configuration
REQ-029 SHALL, when macro TOGGLE_COUNTER_SAT_EN is defined, saturate instead of wrapping: at an up boundary q holds at MODULUS-1, and at a down boundary q holds at 0.
REQ-030 SHALL, when TOGGLE_COUNTER_SAT_EN is defined, still pulse wrap for one cycle on each boundary event, including repeated pulses while en stays high at the limit.
REQ-031 SHALL, when TOGGLE_COUNTER_SAT_EN is undefined, use the wrap behaviour of REQ-018/019; tc, load and reset behaviour are identical in both builds.

Verification
REQ-032 SHALL cover this scenario: WIDTH=4, MODULUS=10; reset, then en=1, up=1 for 12 cycles -> q = 1..9, 0, 1, 2, with wrap high only in the cycle after q=9 was sampled, and tc high while q=9.
REQ-033 SHALL cover this scenario: MODULUS=10, q=0, en=1, up=0 -> q=9 next cycle and wrap=1; with TOGGLE_COUNTER_SAT_EN defined -> q stays 0 and wrap=1.
REQ-034 SHALL cover this scenario: load=1, d=4'd13, MODULUS=10 -> q=9 next cycle and wrap=0; load=1 with en=1 and d=3 -> q=3 (load wins).
REQ-035 SHALL cover this scenario: rst=1 and load=1 asserted together at q=5 -> q=0 and wrap=0; rst pulsed between edges only -> q unchanged.
REQ-036 SHALL cover this scenario: WIDTH=1, MODULUS=2, en=1 for 4 cycles, up toggled randomly -> q = 1, 0, 1, 0 (T flip-flop equivalence).
REQ-037 SHALL cover this scenario: en=0 for 5 cycles at q=7 -> q stays 7, tc=0 and wrap=0 throughout.
